// File: rtl/cdb_writeback_arbiter.sv
// CDB round-robin arbiter + register-bank writeback with Qi (register status) tracking.
// Grant is combinational in the request cycle; broadcast/write registered one cycle later; units hold req until granted.
module cdb_writeback_arbiter #(
   parameter int N_REQ    = 3,
   parameter int TAG_W    = 3,
   parameter int DATA_W   = 16,
   parameter int REG_W    = 4,
   parameter int NUM_REGS = 6
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*TAG_W-1:0]     req_tag,
   input  logic [N_REQ*DATA_W-1:0]    req_data,
   output logic [N_REQ-1:0]           grant,
   input  logic                       issue_valid,
   input  logic [REG_W-1:0]           issue_reg,
   input  logic [TAG_W-1:0]           issue_tag,
   output logic                       cdb_valid,
   output logic [TAG_W-1:0]           cdb_tag,
   output logic [DATA_W-1:0]          cdb_data,
   output logic [DATA_W-1:0]          data,
   output logic [REG_W-1:0]           regnumber,
   output logic                       write,
   output logic [NUM_REGS*TAG_W-1:0]  reg_status
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PTR_W-1:0]  rr_ptr;
   logic [TAG_W-1:0]  qi [NUM_REGS];

   logic              gnt_vld;
   logic [PTR_W-1:0]  gnt_idx;
   logic [TAG_W-1:0]  gnt_tag;
   logic [DATA_W-1:0] gnt_data;
   logic              hit;
   logic [REG_W-1:0]  hit_reg;
   logic [NUM_REGS-1:0] hit_vec;
   logic              issue_ok;

   // Lowest rotated distance from rr_ptr+1 wins; tag 0 means "no producer" and never arbitrates.
   always_comb begin
      int best_d;
      int d;
      best_d   = N_REQ;
      d        = 0;
      gnt_idx  = '0;
      gnt_tag  = '0;
      gnt_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         d = (i + 2*N_REQ - 1 - int'(rr_ptr)) % N_REQ;
         if (reset_n && req[i] && (req_tag[i*TAG_W +: TAG_W] != '0) && (d < best_d)) begin
            best_d   = d;
            gnt_idx  = PTR_W'(i);
            gnt_tag  = req_tag[i*TAG_W +: TAG_W];
            gnt_data = req_data[i*DATA_W +: DATA_W];
         end
      end
      gnt_vld = (best_d < N_REQ);
      grant   = gnt_vld ? (N_REQ'(1) << gnt_idx) : '0;
   end

   always_comb begin
      hit     = 1'b0;
      hit_reg = '0;
      hit_vec = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (gnt_vld && (qi[r] == gnt_tag)) begin
            hit        = 1'b1;
            hit_reg    = REG_W'(r + 1);
            hit_vec[r] = 1'b1;
         end
      end
   end

   assign issue_ok = issue_valid && (issue_tag != '0) && (issue_reg != '0) &&
                     (issue_reg <= REG_W'(NUM_REGS));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr    <= PTR_W'(N_REQ - 1);
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_data  <= '0;
         write     <= 1'b0;
         data      <= '0;
         regnumber <= '0;
         for (int r = 0; r < NUM_REGS; r++) qi[r] <= '0;
      end else begin
         cdb_valid <= gnt_vld;
         write     <= hit;
         if (gnt_vld) begin
            rr_ptr   <= gnt_idx;
            cdb_tag  <= gnt_tag;
            cdb_data <= gnt_data;
         end
         if (hit) begin
            regnumber <= hit_reg;
            data      <= gnt_data;
         end
         // A same-edge rename beats the completion clear: the register now waits on the new tag.
         for (int r = 0; r < NUM_REGS; r++) begin
            if (issue_ok && (issue_reg == REG_W'(r + 1)))
               qi[r] <= issue_tag;
            else if (hit_vec[r])
               qi[r] <= '0;
         end
      end
   end

   always_comb begin
      reg_status = '0;
      for (int r = 0; r < NUM_REGS; r++) reg_status[r*TAG_W +: TAG_W] = qi[r];
   end

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Directed bench for cdb_writeback_arbiter: arbitration order, broadcast, writeback, Qi, reset.
module tb_cdb_writeback_arbiter;

   logic        clock;
   logic        reset_n;
   logic [2:0]  req;
   logic [8:0]  req_tag;
   logic [47:0] req_data;
   logic [2:0]  grant;
   logic        issue_valid;
   logic [3:0]  issue_reg;
   logic [2:0]  issue_tag;
   logic        cdb_valid;
   logic [2:0]  cdb_tag;
   logic [15:0] cdb_data;
   logic [15:0] data;
   logic [3:0]  regnumber;
   logic        write;
   logic [17:0] reg_status;

   int checks   = 0;
   int failures = 0;

   cdb_writeback_arbiter dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req         (req),
      .req_tag     (req_tag),
      .req_data    (req_data),
      .grant       (grant),
      .issue_valid (issue_valid),
      .issue_reg   (issue_reg),
      .issue_tag   (issue_tag),
      .cdb_valid   (cdb_valid),
      .cdb_tag     (cdb_tag),
      .cdb_data    (cdb_data),
      .data        (data),
      .regnumber   (regnumber),
      .write       (write),
      .reg_status  (reg_status)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] qi_of(input int r);
      return reg_status[(r-1)*3 +: 3];
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [3:0] r, input logic [2:0] t);
      issue_valid = 1'b1;
      issue_reg   = r;
      issue_tag   = t;
      tick();
      issue_valid = 1'b0;
   endtask

   initial begin
      reset_n     = 1'b0;
      req         = 3'b001;
      req_tag     = 9'o001;
      req_data    = '0;
      issue_valid = 1'b0;
      issue_reg   = '0;
      issue_tag   = '0;

      // Reset state, including grant suppression while in reset
      #3;
      chk("rst_grant", grant, 3'b000);
      chk("rst_cdb_valid", cdb_valid, 0);
      chk("rst_cdb_tag", cdb_tag, 0);
      chk("rst_write", write, 0);
      chk("rst_regnumber", regnumber, 0);
      chk("rst_data", data, 0);
      chk("rst_reg_status", reg_status, 0);
      tick();
      req = '0;
      reset_n = 1'b1;
      tick();
      tick();
      chk("idle_cdb_valid", cdb_valid, 0);
      chk("idle_write", write, 0);

      // Single result: R3 <- tag 2 from unit 1
      issue(4'd3, 3'd2);
      chk("single_qi_set", qi_of(3), 2);
      req      = 3'b010;
      req_tag  = 9'o020;
      req_data = {16'h0, 16'h00AA, 16'h0};
      #1;
      chk("single_grant", grant, 3'b010);
      tick();
      req = '0;
      chk("single_cdb_valid", cdb_valid, 1);
      chk("single_cdb_tag", cdb_tag, 2);
      chk("single_cdb_data", cdb_data, 16'h00AA);
      chk("single_write", write, 1);
      chk("single_regnumber", regnumber, 3);
      chk("single_data", data, 16'h00AA);
      chk("single_qi_clear", qi_of(3), 0);
      tick();
      chk("single_write_pulse", write, 0);
      chk("single_cdb_drop", cdb_valid, 0);
      chk("single_cdb_tag_hold", cdb_tag, 2);

      // Fresh pointer, then three-way contention
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      issue(4'd1, 3'd1);
      issue(4'd2, 3'd2);
      issue(4'd4, 3'd3);
      chk("cont_qi_r4", qi_of(4), 3);
      req      = 3'b111;
      req_tag  = 9'o321;
      req_data = {16'h3333, 16'h2222, 16'h1111};
      #1;
      chk("cont_grant0", grant, 3'b001);
      tick();
      req = 3'b110;
      chk("cont_wr0_reg", regnumber, 1);
      chk("cont_wr0_data", data, 16'h1111);
      #1;
      chk("cont_grant1", grant, 3'b010);
      tick();
      req = 3'b100;
      chk("cont_wr1_en", write, 1);
      chk("cont_wr1_reg", regnumber, 2);
      #1;
      chk("cont_grant2", grant, 3'b100);
      tick();
      req = 3'b011;
      chk("cont_wr2_en", write, 1);
      chk("cont_wr2_reg", regnumber, 4);
      chk("cont_wr2_data", data, 16'h3333);
      #1;
      chk("cont_wrap_grant", grant, 3'b001);
      tick();
      req = '0;
      chk("cont_wrap_tag", cdb_tag, 1);
      chk("cont_wrap_nowrite", write, 0);
      chk("cont_status_all_clear", reg_status, 0);

      // WAW: only the latest producer of R2 commits
      issue(4'd2, 3'd1);
      issue(4'd2, 3'd4);
      chk("waw_qi_new", qi_of(2), 4);
      req      = 3'b001;
      req_tag  = 9'o001;
      req_data = {16'h0, 16'h0, 16'h0101};
      #1;
      chk("waw_grant_old", grant, 3'b001);
      tick();
      req = '0;
      chk("waw_old_cdb_valid", cdb_valid, 1);
      chk("waw_old_cdb_tag", cdb_tag, 1);
      chk("waw_old_nowrite", write, 0);
      chk("waw_old_qi_kept", qi_of(2), 4);
      req      = 3'b100;
      req_tag  = 9'o400;
      req_data = {16'h0404, 16'h0, 16'h0};
      #1;
      chk("waw_grant_new", grant, 3'b100);
      tick();
      req = '0;
      chk("waw_new_write", write, 1);
      chk("waw_new_reg", regnumber, 2);
      chk("waw_new_data", data, 16'h0404);
      chk("waw_new_qi_clear", qi_of(2), 0);

      // Tag-0 requests never win; out-of-range issues ignored
      req     = 3'b010;
      req_tag = 9'o000;
      #1;
      chk("tag0_grant", grant, 3'b000);
      tick();
      chk("tag0_no_cdb", cdb_valid, 0);
      req = '0;
      issue(4'd0, 3'd5);
      issue(4'd7, 3'd5);
      issue(4'd1, 3'd0);
      chk("bad_issue_ignored", reg_status, 0);

      // Same-edge rename and completion on R5
      issue(4'd5, 3'd3);
      req         = 3'b010;
      req_tag     = 9'o030;
      req_data    = {16'h0, 16'h0555, 16'h0};
      issue_valid = 1'b1;
      issue_reg   = 4'd5;
      issue_tag   = 3'd6;
      #1;
      chk("same_grant", grant, 3'b010);
      tick();
      issue_valid = 1'b0;
      req = '0;
      chk("same_write", write, 1);
      chk("same_reg", regnumber, 5);
      chk("same_data", data, 16'h0555);
      chk("same_qi_new", qi_of(5), 6);

      // Reset in the cycle following a grant
      issue(4'd6, 3'd5);
      req      = 3'b100;
      req_tag  = 9'o500;
      req_data = {16'h0666, 16'h0, 16'h0};
      #1;
      chk("mid_grant", grant, 3'b100);
      tick();
      req = '0;
      chk("mid_pre_write", write, 1);
      reset_n = 1'b0;
      #1;
      chk("mid_cdb_drop", cdb_valid, 0);
      chk("mid_write_drop", write, 0);
      chk("mid_cdb_tag", cdb_tag, 0);
      chk("mid_status_clear", reg_status, 0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("mid_no_write", write, 0);
      req      = 3'b111;
      req_tag  = 9'o321;
      #1;
      chk("mid_resume_unit0", grant, 3'b001);
      tick();
      req = '0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
